// File: rtl/jtgng_objbus.sv
// Object RAM and bus arbiter between the main CPU and the sprite DMA engine.
// The DMA gets the bus only once the CPU acknowledges the halt; the grant is held until DMA drops its request.
module jtgng_objbus #(
    parameter int AW      = 9,
    parameter int HALT_TO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_wrn,
    input  logic          obj_cs,
    input  logic          okout_cs,
    output logic [7:0]    obj_dout,
    output logic          cpu_busrq,
    input  logic          cpu_busak,
    output logic          okout,
    input  logic          bus_req,
    output logic          bus_ack,
    input  logic          blen,
    input  logic [AW-1:0] dma_AB,
    output logic [7:0]    dma_DB,
    output logic          arb_err
);

    // state   | meaning
    // IDLE    | CPU owns the bus, no request pending
    // HALT    | cpu_busrq raised, waiting for cpu_busak (bounded by HALT_TO)
    // GRANT   | bus_ack high, DMA reads object RAM
    // RELEASE | cpu_busrq dropped, waiting for cpu_busak to fall
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HALT    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int CW_RAW = $clog2(HALT_TO + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALT_TO);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busrq_q, busrq_d;
    logic          ack_q, ack_d;
    logic          okout_q, okout_d;
    logic          err_q, err_d;
    logic [7:0]    dma_db_q, dma_db_d;
    logic [7:0]    obj_dout_q, obj_dout_d;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ok_set;

    assign ram_addr = ack_q ? dma_AB : cpu_addr;
    assign ram_we   = cpu_cen & obj_cs & ~cpu_wrn & ~ack_q;
    assign ok_set   = cpu_cen & okout_cs & ~cpu_wrn;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= cpu_dout;
        ram_q <= mem[ram_addr];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busrq_d    = busrq_q;
        ack_d      = ack_q;
        err_d      = err_q;
        dma_db_d   = dma_db_q;
        obj_dout_d = obj_dout_q;

        case (state_q)
            IDLE: if (bus_req) begin
                state_d = HALT;
                busrq_d = 1'b1;
                cnt_d   = '0;
            end
            HALT: begin
                if (cpu_busak) begin
                    state_d = GRANT;
                    ack_d   = 1'b1;
                end else if (!bus_req) begin
                    state_d = RELEASE;
                    busrq_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RELEASE;
                    busrq_d = 1'b0;
                    err_d   = 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GRANT: if (!bus_req) begin
                state_d = RELEASE;
                ack_d   = 1'b0;
                busrq_d = 1'b0;
            end
            default: if (!cpu_busak) state_d = IDLE;
        endcase

        // The DMA ignores dma_DB while blen is low, so both cases track the RAM.
        if (ack_q) begin
            if (blen) dma_db_d = ram_q;
            else      dma_db_d = ram_q;
        end
        if (obj_cs && cpu_wrn && !ack_q) obj_dout_d = ram_q;

        // A new trigger wins over the clear caused by the grant edge.
        if (ok_set)              okout_d = 1'b1;
        else if (ack_d && !ack_q) okout_d = 1'b0;
        else                     okout_d = okout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busrq_q    <= 1'b0;
            ack_q      <= 1'b0;
            okout_q    <= 1'b0;
            err_q      <= 1'b0;
            dma_db_q   <= 8'h00;
            obj_dout_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busrq_q    <= busrq_d;
            ack_q      <= ack_d;
            okout_q    <= okout_d;
            err_q      <= err_d;
            dma_db_q   <= dma_db_d;
            obj_dout_q <= obj_dout_d;
        end
    end

    assign cpu_busrq = busrq_q;
    assign bus_ack   = ack_q;
    assign okout     = okout_q;
    assign arb_err   = err_q;
    assign dma_DB    = dma_db_q;
    assign obj_dout  = obj_dout_q;

endmodule

// File: tb/tb_jtgng_objbus.sv
// Directed bench for jtgng_objbus: OKOUT trigger, halt/grant handshake, DMA data path,
// write blocking, timeout, abort and reset during grant.
module tb_jtgng_objbus;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_cen;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_wrn;
    logic          obj_cs;
    logic          okout_cs;
    logic [7:0]    obj_dout;
    logic          cpu_busrq;
    logic          cpu_busak;
    logic          okout;
    logic          bus_req;
    logic          bus_ack;
    logic          blen;
    logic [AW-1:0] dma_AB;
    logic [7:0]    dma_DB;
    logic          arb_err;

    int total = 0;
    int bad   = 0;
    logic saw_ack;

    jtgng_objbus #(.AW(AW), .HALT_TO(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_cen  (cpu_cen),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_wrn  (cpu_wrn),
        .obj_cs   (obj_cs),
        .okout_cs (okout_cs),
        .obj_dout (obj_dout),
        .cpu_busrq(cpu_busrq),
        .cpu_busak(cpu_busak),
        .okout    (okout),
        .bus_req  (bus_req),
        .bus_ack  (bus_ack),
        .blen     (blen),
        .dma_AB   (dma_AB),
        .dma_DB   (dma_DB),
        .arb_err  (arb_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dout = d; cpu_cen = 1'b1; obj_cs = 1'b1; cpu_wrn = 1'b0;
        tick();
        cpu_cen = 1'b0; obj_cs = 1'b0; cpu_wrn = 1'b1;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a);
        cpu_addr = a; obj_cs = 1'b1; cpu_wrn = 1'b1;
        tick(2);
        obj_cs = 1'b0;
    endtask

    task automatic ok_wr();
        cpu_cen = 1'b1; okout_cs = 1'b1; cpu_wrn = 1'b0;
        tick();
        cpu_cen = 1'b0; okout_cs = 1'b0; cpu_wrn = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cpu_cen = 1'b0; cpu_addr = '0; cpu_dout = 8'h00; cpu_wrn = 1'b1;
        obj_cs = 1'b0; okout_cs = 1'b0; cpu_busak = 1'b0; bus_req = 1'b0;
        blen = 1'b0; dma_AB = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_busrq", 16'(cpu_busrq), 16'h0);
        chk("rst_ack",   16'(bus_ack),   16'h0);
        chk("rst_okout", 16'(okout),     16'h0);
        chk("rst_err",   16'(arb_err),   16'h0);
        chk("rst_objd",  16'(obj_dout),  16'h00);
        chk("rst_dmadb", 16'(dma_DB),    16'h00);

        cpu_wr(9'h000, 8'h5A);
        cpu_wr(9'h17F, 8'hA5);
        cpu_wr(9'h010, 8'h33);
        cpu_rd(9'h010);
        chk("rd_010", 16'(obj_dout), 16'h33);
        cpu_rd(9'h17F);
        chk("rd_17f", 16'(obj_dout), 16'hA5);

        ok_wr();
        chk("okout_set", 16'(okout), 16'h1);
        tick(3);
        chk("okout_hold", 16'(okout), 16'h1);

        bus_req = 1'b1;
        tick();
        chk("hs_busrq", 16'(cpu_busrq), 16'h1);
        chk("hs_noack", 16'(bus_ack),   16'h0);
        tick(4);
        chk("hs_wait_ack", 16'(bus_ack), 16'h0);
        chk("hs_wait_ok",  16'(okout),   16'h1);
        cpu_busak = 1'b1;
        tick();
        chk("hs_ack",       16'(bus_ack),   16'h1);
        chk("hs_okout_clr", 16'(okout),     16'h0);
        chk("hs_busrq_hi",  16'(cpu_busrq), 16'h1);

        blen = 1'b1; dma_AB = 9'h17F;
        tick(2);
        chk("dma_17f", 16'(dma_DB), 16'hA5);
        blen = 1'b0; dma_AB = 9'h000;
        tick(2);
        chk("dma_000_blen0", 16'(dma_DB), 16'h5A);

        cpu_wr(9'h010, 8'hFF);
        obj_cs = 1'b1; tick(2); obj_cs = 1'b0;
        chk("objd_hold_grant", 16'(obj_dout), 16'hA5);

        cpu_busak = 1'b0;
        tick();
        chk("grant_busak_low", 16'(bus_ack), 16'h1);
        cpu_busak = 1'b1;

        bus_req = 1'b0;
        tick();
        chk("rel_ack",   16'(bus_ack),   16'h0);
        chk("rel_busrq", 16'(cpu_busrq), 16'h0);
        bus_req = 1'b1;
        tick(2);
        chk("rel_ignore_req", 16'(cpu_busrq), 16'h0);
        bus_req = 1'b0; cpu_busak = 1'b0;
        tick(2);
        cpu_rd(9'h010);
        chk("write_blocked", 16'(obj_dout), 16'h33);

        bus_req = 1'b1;
        tick();
        chk("abort_busrq", 16'(cpu_busrq), 16'h1);
        tick(2);
        bus_req = 1'b0;
        tick();
        chk("abort_busrq_lo", 16'(cpu_busrq), 16'h0);
        chk("abort_noack",    16'(bus_ack),   16'h0);
        chk("abort_noerr",    16'(arb_err),   16'h0);
        tick(2);

        saw_ack = 1'b0;
        bus_req = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_ack = saw_ack | bus_ack;
        end
        chk("to_busrq_still", 16'(cpu_busrq), 16'h1);
        chk("to_err_before",  16'(arb_err),   16'h0);
        tick();
        chk("to_busrq_lo", 16'(cpu_busrq), 16'h0);
        chk("to_err",      16'(arb_err),   16'h1);
        chk("to_noack",    16'(saw_ack),   16'h0);
        bus_req = 1'b0;
        tick(4);
        chk("to_err_sticky", 16'(arb_err), 16'h1);

        bus_req = 1'b1;
        tick();
        cpu_busak = 1'b1;
        tick();
        chk("g2_ack", 16'(bus_ack), 16'h1);
        ok_wr();
        chk("g2_okout", 16'(okout), 16'h1);
        rst = 1'b1;
        tick();
        chk("rstg_ack",   16'(bus_ack),   16'h0);
        chk("rstg_busrq", 16'(cpu_busrq), 16'h0);
        chk("rstg_okout", 16'(okout),     16'h0);
        chk("rstg_err",   16'(arb_err),   16'h0);
        chk("rstg_dmadb", 16'(dma_DB),    16'h00);
        rst = 1'b0; bus_req = 1'b0; cpu_busak = 1'b0;
        tick(2);
        chk("post_rst_ack", 16'(bus_ack), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtgng_objbus.md
# jtgng_objbus

CPU-side responder for the object DMA bus protocol. Holds the 512-byte object RAM shared between main CPU and sprite DMA, generates the OKOUT trigger from a CPU register write, and arbitrates the bus. On a DMA bus_req it halts the CPU, waits for the CPU's bus acknowledge, returns bus_ack and serves DMA reads. Sits between the main CPU address decoder and the object DMA engine.

## Interface
Parameters:
- AW, 9, object RAM address width (2^AW bytes)
- HALT_TO, 255, max clk cycles to wait for cpu_busak before aborting a request

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cpu_cen  in  1  CPU clock enable; all CPU-side accesses qualify on it
- cpu_addr  in  AW  CPU address into object RAM
- cpu_dout  in  8  CPU write data
- cpu_wrn  in  1  CPU write strobe, active low
- obj_cs  in  1  CPU selects object RAM
- okout_cs  in  1  CPU selects OKOUT register (any write triggers DMA)
- obj_dout  out  8  object RAM read data to CPU
- cpu_busrq  out  1  bus request/halt to CPU
- cpu_busak  in  1  CPU has released the bus
- okout  out  1  DMA start trigger
- bus_req  in  1  DMA requests bus
- bus_ack  out  1  bus granted to DMA
- blen  in  1  DMA address counter active
- dma_AB  in  AW  DMA read address
- dma_DB  out  8  object RAM data to DMA
- arb_err  out  1  sticky: a request timed out waiting for cpu_busak

## Operation
- Reset values: cpu_busrq=0, bus_ack=0, okout=0, obj_dout=0, dma_DB=0, arb_err=0, state IDLE, timeout counter 0. RAM contents not cleared.
- okout: set on clk where cpu_cen & okout_cs & !cpu_wrn. Cleared on the clk bus_ack goes 1. Set has priority over clear if coincident. Stays high otherwise (DMA samples only on its own cen6).
- State machine (registered, evaluated every clk):
  - IDLE: bus_req=1 -> HALT, cpu_busrq<=1, counter<=0.
  - HALT: cpu_busak=1 -> GRANT, bus_ack<=1. Else bus_req=0 -> RELEASE, cpu_busrq<=0. Else counter==HALT_TO -> RELEASE, cpu_busrq<=0, arb_err<=1. Else counter++ (saturating width ceil(log2(HALT_TO+1))).
  - GRANT: bus_req=0 -> RELEASE, bus_ack<=0, cpu_busrq<=0. bus_ack held while bus_req=1 regardless of cpu_busak.
  - RELEASE: cpu_busak=0 -> IDLE. bus_req ignored in this state.
- RAM port mux: address = dma_AB when bus_ack=1, else cpu_addr. Write enable = cpu_cen & obj_cs & !cpu_wrn & !bus_ack. CPU writes during GRANT are dropped.
- Read: single synchronous port, registered output q. dma_DB<=q when bus_ack=1, else holds. obj_dout<=q when obj_cs & cpu_wrn & !bus_ack, else holds.
- blen only qualifies dma_DB updates: when bus_ack=1 and blen=0, dma_DB still tracks q (DMA ignores it).
- arb_err cleared only by rst.

## Timing
- bus_req rise at clk n -> cpu_busrq=1 at n+1.
- cpu_busak rise at clk m (in HALT) -> bus_ack=1 at m+1, okout=0 at m+1.
- bus_req fall at clk k (GRANT) -> bus_ack=0 and cpu_busrq=0 at k+1.
- RAM read latency: address at clk t -> q at t+1 -> dma_DB/obj_dout at t+2. DMA address changes every 2 cen6 ticks, so data is stable before its sample point.
- CPU write: committed on the cpu_cen clk; readable by a read address presented the next clk.
- Timeout: with cpu_busak stuck 0, cpu_busrq falls HALT_TO+1 clk after entering HALT; arb_err rises same clk.
- Reset mid-GRANT: next clk all outputs at reset values; DMA sees bus_ack=0 and stalls in its wait state until re-grant.

## Test plan
- OKOUT: CPU write to okout_cs at cpu_cen -> okout=1 next clk, held until bus_ack rises, then 0.
- Full handshake: bus_req=1 @t0, cpu_busak=1 @t0+5 -> cpu_busrq @t0+1, bus_ack @t0+6; bus_req=0 @t1 -> bus_ack=0, cpu_busrq=0 @t1+1; cpu_busak=0 -> IDLE next clk.
- Data path: CPU writes 0x5A at 0x000, 0xA5 at 0x17F; granted DMA drives dma_AB=0x17F -> dma_DB=0xA5 two clk later; 0x000 -> 0x5A.
- Write block: CPU write 0xFF to 0x010 while bus_ack=1 -> after release, CPU read of 0x010 returns prior value.
- Timeout: HALT_TO=15, cpu_busak held 0 -> cpu_busrq falls after 16 clk in HALT, arb_err=1 until rst.
- Abort/reset: bus_req drops in HALT -> RELEASE without bus_ack pulse; rst during GRANT -> bus_ack, cpu_busrq, okout all 0 next clk.
